// File: rtl/ps2_bus_sched.sv
// ps2_bus_sched: 68k-side register file for a PS/2 port: receive FIFO, STATUS, TX handshake FSM.
// Define PS2_IRQ_EN to build the registered interrupt output and the irq_en control bit.
module ps2_bus_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_sel,
  input  logic       rd_lvl,
  input  logic       wr_lvl,
  input  logic [7:0] wr_data,
  output logic [7:0] read_reg,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ack,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic rd_q, wr_q;
  logic [7:0] tx_data_q, tx_data_d;
  logic irq_en;
  logic rd_rise, wr_rise, not_empty, full, pop, push;
  logic [7:0] status;
  assign rd_rise   = rd_lvl & ~rd_q;
  assign wr_rise   = wr_lvl & ~wr_q;
  assign not_empty = cnt_q != '0;
  assign full      = cnt_q == FULL_CNT;
  assign pop       = rd_rise & ~reg_sel & not_empty;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the byte
  assign push      = rx_valid & (~full | pop);
  assign status    = {3'b000, irq_en, state_q != IDLE, ovf_q, full, not_empty};
  assign read_reg  = reg_sel ? status : (not_empty ? mem_q[rp_q] : 8'h00);
  assign tx_data   = tx_data_q;
  assign tx_req    = state_q == REQ;
  always_comb begin
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (rx_valid & full & ~pop) | (ovf_q & ~(wr_rise & reg_sel & wr_data[2]));
  end
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (wr_rise && !reg_sel) begin
        state_d   = REQ;
        tx_data_d = wr_data;
      end
      REQ:     state_d = tx_ack ? RELEASE : REQ;
      RELEASE: state_d = tx_ack ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_lvl;
      wr_q      <= wr_lvl;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= rx_data;
  end
`ifdef PS2_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign irq_en_d = (wr_rise & reg_sel) ? wr_data[4] : irq_en_q;
  assign irq_d    = irq_en_q & (not_empty | ovf_q);
  assign irq_en   = irq_en_q;
  assign irq      = irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif
endmodule
